// File: rtl/rx_ten_eight_spec_pkg.sv
// Shared types, constants and helpers for the 10/8-bit serial receiver.
package rx_ten_eight_spec_pkg;

  localparam int MAX_BITS = 10;
  localparam int MIN_BITS = 8;
  localparam int BAUD_W   = 20;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Periods below 2 cycles cannot place a mid-bit sample, so clamp to 2.
  function automatic logic [BAUD_W-1:0] eff_period(input logic [BAUD_W-1:0] baud);
    return (baud < BAUD_W'(2)) ? BAUD_W'(2) : baud;
  endfunction

endpackage

// File: rtl/rx_ten_eight_spec_baud_gen.sv
// Bit-period counter: counts from a restart and flags the half- and full-period sample points.
module rx_baud_gen
  import rx_ten_eight_spec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic [BAUD_W-1:0] baud,
  output logic              half_tick,
  output logic              full_tick
);

  logic [BAUD_W-1:0] cnt;
  logic [BAUD_W-1:0] period;
  logic [BAUD_W-1:0] half_m1;
  logic [BAUD_W-1:0] full_m1;

  // The period is captured on every restart so a new baud only takes effect at the next period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      period <= BAUD_W'(2);
    end else if (restart) begin
      cnt    <= '0;
      period <= eff_period(baud);
    end else begin
      cnt    <= cnt + BAUD_W'(1);
    end
  end

  assign half_m1   = {1'b0, period[BAUD_W-1:1]} - BAUD_W'(1);
  assign full_m1   = period - BAUD_W'(1);
  assign half_tick = (cnt == half_m1);
  assign full_tick = (cnt == full_m1);

endmodule

// File: rtl/rx_ten_eight_spec.sv
// UART-style receiver with selectable 10- or 8-bit frames, 2-flop line synchronizer and framing check.
module rx_ten_eight_spec
  import rx_ten_eight_spec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic [BAUD_W-1:0] baud,
  input  logic              rx_en,
  input  logic              rx_in,
  output logic [7:0]        rx_data,
  output logic [9:0]        data_o,
  output logic [9:0]        bit_cnt_out,
  output logic              baud_clk
);

  state_t              state, state_nxt;
  logic                sync1, line, line_q, fall;
  logic [3:0]          bit_cnt, last_idx;
  logic                ten_q;
  logic [MAX_BITS-1:0] shift;
  logic                half_tick, full_tick;
  logic                restart, data_smp, commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      line   <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync1  <= rx_in;
      line   <= sync1;
      line_q <= line;
    end
  end

  assign fall     = line_q & ~line;
  assign last_idx = ten_q ? 4'(MAX_BITS - 1) : 4'(MIN_BITS - 1);

  rx_baud_gen u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .baud      (baud),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    baud_clk  = 1'b0;
    restart   = 1'b0;
    data_smp  = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        restart = 1'b1;
        if (rx_en && fall) state_nxt = START;
      end
      START: if (half_tick) begin
        baud_clk  = 1'b1;
        restart   = 1'b1;
        state_nxt = line ? IDLE : DATA;
      end
      DATA: if (full_tick) begin
        baud_clk = 1'b1;
        restart  = 1'b1;
        data_smp = 1'b1;
        if (bit_cnt == last_idx) state_nxt = STOP;
      end
      STOP: if (full_tick) begin
        baud_clk  = 1'b1;
        restart   = 1'b1;
        commit    = line;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Disabling wins over everything: drop the frame and stop sampling.
    if (!rx_en) begin
      state_nxt = IDLE;
      baud_clk  = 1'b0;
      restart   = 1'b1;
      data_smp  = 1'b0;
      commit    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      ten_q   <= 1'b0;
      shift   <= '0;
      data_o  <= '0;
      rx_data <= '0;
    end else begin
      if (state_nxt != DATA) bit_cnt <= '0;
      else if (data_smp)     bit_cnt <= bit_cnt + 4'd1;

      if (state == IDLE && state_nxt == START) ten_q <= sel;

      if (state == IDLE)  shift          <= '0;
      else if (data_smp)  shift[bit_cnt] <= line;

      if (commit) begin
        data_o  <= ten_q ? shift : {{(MAX_BITS-MIN_BITS){1'b0}}, shift[MIN_BITS-1:0]};
        rx_data <= shift[MIN_BITS-1:0];
      end
    end
  end

  assign bit_cnt_out = {{(MAX_BITS-4){1'b0}}, bit_cnt};

endmodule

// File: tb/tb_rx_ten_eight_spec.sv
// Bench for rx_ten_eight_spec: directed scenarios plus randomized frames against a frame-level model.
module tb_rx_ten_eight_spec;

  logic        clk = 1'b0;
  logic        rst, sel, rx_en, rx_in;
  logic [19:0] baud;
  logic [7:0]  rx_data;
  logic [9:0]  data_o;
  logic [9:0]  bit_cnt_out;
  logic        baud_clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [9:0] exp_data;
  logic [7:0] exp_rx;
  int         pulse_t[$];
  logic [9:0] pulse_b[$];

  rx_ten_eight_spec dut (
    .clk         (clk),
    .rst         (rst),
    .sel         (sel),
    .baud        (baud),
    .rx_en       (rx_en),
    .rx_in       (rx_in),
    .rx_data     (rx_data),
    .data_o      (data_o),
    .bit_cnt_out (bit_cnt_out),
    .baud_clk    (baud_clk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every sample pulse with its cycle stamp and the bit index shown at that moment.
  always @(negedge clk) begin
    if (baud_clk === 1'b1) begin
      pulse_t.push_back(cyc);
      pulse_b.push_back(bit_cnt_out);
    end
  end

  // Frame-level reference: a good stop bit publishes the word truncated to its width.
  function automatic void model_frame(input logic [9:0] word, input bit ten, input bit stop_ok);
    if (stop_ok) begin
      exp_data = ten ? word : {2'b00, word[7:0]};
      exp_rx   = word[7:0];
    end
  endfunction

  task automatic drive_bit(input logic v, input int cycles);
    rx_in = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [9:0] word, input bit ten, input bit stop_bit,
                            input int p, input int idle, input bit flip_sel);
    int n;
    n   = ten ? 10 : 8;
    sel = ten;
    drive_bit(1'b0, p);
    for (int i = 0; i < n; i++) begin
      if (flip_sel && i == 1) sel = ~sel;
      drive_bit(word[i], p);
    end
    drive_bit(stop_bit, p);
    if (idle > 0) drive_bit(1'b1, idle);
  endtask

  task automatic clear_pulses();
    pulse_t.delete();
    pulse_b.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_en = 1'b0; rx_in = 1'b1; sel = 1'b0; baud = 20'd20;
    exp_data = '0; exp_rx = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (data_o !== 10'h000) begin errors++; $display("FAIL reset_data_o got=%h exp=000", data_o); end
    checks++; if (bit_cnt_out !== 10'd0) begin errors++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt_out); end
    checks++; if (baud_clk !== 1'b0) begin errors++; $display("FAIL reset_baud_clk got=%b exp=0", baud_clk); end
    rst = 1'b0;
    rx_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_ten_bit_frame();
    logic [9:0] w;
    w = 10'b0010111011;
    baud = 20'd20;
    clear_pulses();
    send_frame(w, 1'b1, 1'b1, 20, 24, 1'b0);
    model_frame(w, 1'b1, 1'b1);
    checks++; if (data_o !== exp_data) begin errors++; $display("FAIL ten_data_o got=%h exp=%h", data_o, exp_data); end
    checks++; if (rx_data !== 8'hBB) begin errors++; $display("FAIL ten_rx_data got=%h exp=bb", rx_data); end
    checks++; if (pulse_t.size() !== 12) begin errors++; $display("FAIL ten_pulse_count got=%0d exp=12", pulse_t.size()); end
    for (int i = 1; i < pulse_t.size(); i++) begin
      checks++;
      if (pulse_t[i] - pulse_t[i-1] !== 20) begin
        errors++; $display("FAIL ten_pulse_gap[%0d] got=%0d exp=20", i, pulse_t[i] - pulse_t[i-1]);
      end
    end
  endtask

  task automatic test_byte_frame();
    baud = 20'd20;
    clear_pulses();
    send_frame(10'h0A5, 1'b0, 1'b1, 20, 24, 1'b0);
    model_frame(10'h0A5, 1'b0, 1'b1);
    checks++; if (data_o !== exp_data) begin errors++; $display("FAIL byte_data_o got=%h exp=%h", data_o, exp_data); end
    checks++; if (rx_data !== exp_rx) begin errors++; $display("FAIL byte_rx_data got=%h exp=%h", rx_data, exp_rx); end
    checks++; if (pulse_b.size() !== 10) begin errors++; $display("FAIL byte_pulse_count got=%0d exp=10", pulse_b.size()); end
    if (pulse_b.size() == 10) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (pulse_b[i+1] !== 10'(i)) begin
          errors++; $display("FAIL byte_bit_cnt[%0d] got=%0d exp=%0d", i, pulse_b[i+1], i);
        end
      end
      checks++; if (pulse_b[9] !== 10'd0) begin errors++; $display("FAIL byte_stop_bit_cnt got=%0d exp=0", pulse_b[9]); end
    end
  endtask

  task automatic test_glitch();
    baud = 20'd20;
    clear_pulses();
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 40);
    checks++; if (pulse_t.size() !== 1) begin errors++; $display("FAIL glitch_pulse_count got=%0d exp=1", pulse_t.size()); end
    checks++; if (data_o !== exp_data) begin errors++; $display("FAIL glitch_data_o got=%h exp=%h", data_o, exp_data); end
    checks++; if (rx_data !== exp_rx) begin errors++; $display("FAIL glitch_rx_data got=%h exp=%h", rx_data, exp_rx); end
    checks++; if (bit_cnt_out !== 10'd0) begin errors++; $display("FAIL glitch_bit_cnt got=%0d exp=0", bit_cnt_out); end
  endtask

  task automatic test_framing_error();
    logic [9:0] w;
    w = 10'($urandom);
    baud = 20'd16;
    clear_pulses();
    send_frame(w, 1'b1, 1'b0, 16, 20, 1'b0);
    model_frame(w, 1'b1, 1'b0);
    checks++; if (pulse_t.size() !== 12) begin errors++; $display("FAIL frm_pulse_count got=%0d exp=12", pulse_t.size()); end
    checks++; if (data_o !== exp_data) begin errors++; $display("FAIL frm_data_o got=%h exp=%h", data_o, exp_data); end
    checks++; if (rx_data !== exp_rx) begin errors++; $display("FAIL frm_rx_data got=%h exp=%h", rx_data, exp_rx); end
  endtask

  task automatic test_abort(input bit use_rst);
    logic [9:0] w;
    w = 10'($urandom);
    baud = 20'd20;
    sel = 1'b1;
    clear_pulses();
    drive_bit(1'b0, 20);
    for (int i = 0; i < 4; i++) drive_bit(w[i], 20);
    drive_bit(w[4], 5);
    checks++; if (bit_cnt_out !== 10'd4) begin errors++; $display("FAIL abort%0d_mid_bit_cnt got=%0d exp=4", use_rst, bit_cnt_out); end
    if (use_rst) begin
      rst = 1'b1;
      #1;
      exp_data = '0; exp_rx = '0;
      checks++; if (bit_cnt_out !== 10'd0) begin errors++; $display("FAIL abort_rst_bit_cnt got=%0d exp=0", bit_cnt_out); end
      @(posedge clk); #1;
      rx_in = 1'b1;
      rst = 1'b0;
    end else begin
      rx_en = 1'b0;
      @(posedge clk); #1;
      checks++; if (bit_cnt_out !== 10'd0) begin errors++; $display("FAIL abort_en_bit_cnt got=%0d exp=0", bit_cnt_out); end
    end
    drive_bit(1'b1, 60);
    rx_en = 1'b1;
    drive_bit(1'b1, 4);
    checks++; if (pulse_t.size() !== 5) begin errors++; $display("FAIL abort%0d_pulse_count got=%0d exp=5", use_rst, pulse_t.size()); end
    checks++; if (data_o !== exp_data) begin errors++; $display("FAIL abort%0d_data_o got=%h exp=%h", use_rst, data_o, exp_data); end
    checks++; if (rx_data !== exp_rx) begin errors++; $display("FAIL abort%0d_rx_data got=%h exp=%h", use_rst, rx_data, exp_rx); end
    w = 10'($urandom);
    send_frame(w, 1'b1, 1'b1, 20, 24, 1'b0);
    model_frame(w, 1'b1, 1'b1);
    checks++; if (data_o !== exp_data) begin errors++; $display("FAIL abort%0d_next_data_o got=%h exp=%h", use_rst, data_o, exp_data); end
    checks++; if (rx_data !== exp_rx) begin errors++; $display("FAIL abort%0d_next_rx_data got=%h exp=%h", use_rst, rx_data, exp_rx); end
  endtask

  task automatic test_baud_zero();
    logic [9:0] w;
    int bad;
    w = 10'($urandom);
    baud = 20'd0;
    clear_pulses();
    send_frame(w, 1'b1, 1'b1, 2, 8, 1'b0);
    model_frame(w, 1'b1, 1'b1);
    bad = 0;
    for (int i = 1; i < pulse_t.size(); i++) if (pulse_t[i] - pulse_t[i-1] != 2) bad++;
    checks++; if (data_o !== exp_data) begin errors++; $display("FAIL baud0_data_o got=%h exp=%h", data_o, exp_data); end
    checks++; if (pulse_t.size() !== 12) begin errors++; $display("FAIL baud0_pulse_count got=%0d exp=12", pulse_t.size()); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL baud0_pulse_gaps bad_gaps=%0d exp=0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] w0, w1;
    w0 = 10'($urandom);
    w1 = 10'($urandom);
    baud = 20'd12;
    clear_pulses();
    send_frame(w0, 1'b0, 1'b1, 12, 0, 1'b0);
    model_frame(w0, 1'b0, 1'b1);
    checks++; if (data_o !== exp_data) begin errors++; $display("FAIL b2b_first_data_o got=%h exp=%h", data_o, exp_data); end
    send_frame(w1, 1'b1, 1'b1, 12, 16, 1'b0);
    model_frame(w1, 1'b1, 1'b1);
    checks++; if (pulse_t.size() !== 22) begin errors++; $display("FAIL b2b_pulse_count got=%0d exp=22", pulse_t.size()); end
    checks++; if (data_o !== exp_data) begin errors++; $display("FAIL b2b_data_o got=%h exp=%h", data_o, exp_data); end
    checks++; if (rx_data !== exp_rx) begin errors++; $display("FAIL b2b_rx_data got=%h exp=%h", rx_data, exp_rx); end
  endtask

  task automatic test_random();
    logic [9:0] w;
    bit ten, stop_ok, flip;
    int p, n, bad_gap, bad_idx;
    for (int k = 0; k < 24; k++) begin
      w       = 10'($urandom);
      ten     = 1'($urandom_range(0, 1));
      stop_ok = ($urandom_range(0, 4) != 0);
      flip    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) baud = 20'($urandom_range(0, 1));
      else                           baud = 20'($urandom_range(3, 30));
      p = (baud < 2) ? 2 : int'(baud);
      n = ten ? 10 : 8;
      clear_pulses();
      send_frame(w, ten, stop_ok, p, p + 4, flip);
      model_frame(w, ten, stop_ok);
      bad_gap = 0;
      bad_idx = 0;
      for (int i = 1; i < pulse_t.size(); i++) if (pulse_t[i] - pulse_t[i-1] != p) bad_gap++;
      for (int i = 1; i < pulse_b.size() - 1; i++) if (pulse_b[i] != 10'(i - 1)) bad_idx++;
      checks++; if (data_o !== exp_data) begin errors++; $display("FAIL rnd%0d_data_o got=%h exp=%h", k, data_o, exp_data); end
      checks++; if (rx_data !== exp_rx) begin errors++; $display("FAIL rnd%0d_rx_data got=%h exp=%h", k, rx_data, exp_rx); end
      checks++; if (pulse_t.size() !== n + 2) begin errors++; $display("FAIL rnd%0d_pulse_count got=%0d exp=%0d", k, pulse_t.size(), n + 2); end
      checks++; if (bad_gap !== 0) begin errors++; $display("FAIL rnd%0d_pulse_gaps bad_gaps=%0d exp=0 period=%0d", k, bad_gap, p); end
      checks++; if (bad_idx !== 0) begin errors++; $display("FAIL rnd%0d_bit_index bad_indices=%0d exp=0", k, bad_idx); end
    end
  endtask

  initial begin
    test_reset();
    test_ten_bit_frame();
    test_byte_frame();
    test_glitch();
    test_framing_error();
    test_abort(1'b0);
    test_abort(1'b1);
    test_baud_zero();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_ten_eight_spec.md
RX_TEN_EIGHT_SPEC -- requirements
Module: rx_ten_eight

Interface
REQ-001 SHALL have port clk, input, 1 bit; the single clock, and all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
REQ-003 SHALL have port sel, input, 1 bit; frame width select: 1 = 10 data bits, 0 = 8 data bits.
REQ-004 SHALL have port baud, input, 20 bits; clock cycles per serial bit (unsigned).
REQ-005 SHALL have port rx_en, input, 1 bit; receiver enable.
REQ-006 SHALL have port rx_in, input, 1 bit; serial line, idle high.
REQ-007 SHALL have port rx_data, output, 8 bits; low 8 bits of the last good frame.
REQ-008 SHALL have port data_o, output, 10 bits; full last good frame, LSB = first data bit.
REQ-009 SHALL have port bit_cnt_out, output, 10 bits; index of the data bit currently being received, zero-extended.
REQ-010 SHALL have port baud_clk, output, 1 bit; one-cycle pulse at every line sample point.

Function
REQ-011 Line input SHALL pass through a 2-flop synchronizer; all timing below refers to the synchronized line.
REQ-012 Effective bit period P SHALL be baud, or 2 if baud < 2.
REQ-013 States SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE: with rx_en=1 and a high-to-low line transition, go to START, clear the bit-period counter, and latch sel as frame width N (10 or 8).
REQ-015 START: after P/2 cycles (integer division), sample the line and pulse baud_clk; low goes to DATA, high (glitch) returns to IDLE.
REQ-016 DATA: every P cycles, sample one bit into shift-register position bit_cnt_out (LSB first) and pulse baud_clk; after bit N-1 go to STOP.
REQ-017 bit_cnt_out SHALL increment after each data sample and be 0 in IDLE, START and STOP.
REQ-018 STOP: after P cycles, sample the line and pulse baud_clk.
REQ-019 A high stop bit SHALL commit the frame in the same cycle: data_o = received word with bits above N-1 forced to 0, and rx_data = word[7:0].
REQ-020 A low stop bit (framing error) SHALL discard the frame, leaving outputs unchanged.
REQ-021 After STOP, the receiver SHALL return to IDLE and require a fresh falling edge.
REQ-022 rx_en=0 in any state SHALL force IDLE on the next edge and discard the partial frame; committed outputs are held.
REQ-023 Changes of sel or baud mid-frame SHALL not affect the current frame; the new baud applies from the next period restart.
REQ-024 Committed outputs SHALL change only on a good stop bit or on reset.

Reset
REQ-025 Reset SHALL force state IDLE, all counters, the shift register and the synchronizer to their idle values (synchronizer = 1).
REQ-026 Reset SHALL force outputs rx_data=8'h00, data_o=10'h000, bit_cnt_out=0 and baud_clk=0.
REQ-027 Reset mid-frame SHALL abort the frame with no output update.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/START/DATA/STOP) and constants MAX_BITS=10, MIN_BITS=8 and BAUD_W=20.
REQ-029 One sub-module, rx_baud_gen, SHALL hold the 20-bit period counter and produce the half-period and full-period sample ticks.

Verification
REQ-030 Scenario: baud=20, sel=1, rx_en=1, frame 0 then 1,1,0,1,1,1,0,1,0,0 then stop 1. Required: data_o=10'b0010111011 and rx_data=8'hBB, with 12 baud_clk pulses 20 cycles apart after the first.
REQ-031 Scenario: baud=20, sel=0, byte 8'hA5 LSB first, stop 1. Required: data_o=10'h0A5, rx_data=8'hA5, bit_cnt_out counting 0..7.
REQ-032 Scenario: baud=20, line low for 5 cycles only. Required: return to IDLE and outputs unchanged.
REQ-033 Scenario: sel=1 frame with stop bit 0. Required: previous data_o and rx_data retained.
REQ-034 Scenario: rx_en dropped, or rst asserted, at data bit 4. Required: IDLE immediately, bit_cnt_out=0, and a following good frame is received correctly (after reset, outputs are 0 until then).
REQ-035 Scenario: baud=0 with 1 bit every 2 cycles. Required: frame received as if baud=2.
